// File: rtl/i2s_in.sv
// I2S slave receiver: synchronises external bclk/ws/data into clk_in,
// deserialises 16-bit MSB-first words per channel and presents each
// completed left+right frame with a one-cycle data_valid_out strobe.
// MSB_DELAY = 1 selects standard I2S framing, 0 selects left-justified.
// SYNC_STAGES (>= 2) sets the synchroniser depth on every serial input.
// Optional feature macro: I2S_IN_MONO_MIX_EN adds mono_out = (L + R) >>> 1.
// bclk_in must run at no more than clk_in/4.
module i2s_in #(
  parameter int MSB_DELAY   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        bclk_in,
  input  logic        ws_in,
  input  logic        d_in,
  output logic [15:0] left_out,
  output logic [15:0] right_out,
  output logic        data_valid_out,
  output logic        frame_err_out
`ifdef I2S_IN_MONO_MIX_EN
  ,
  output logic [15:0] mono_out
`endif
);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, d_sync;
  logic                   bclk_s, ws_s, d_s;
  logic                   bclk_prev;
  logic                   brise, ws_edge;
  logic                   ws_last;

  state_t      state;
  logic [15:0] shift_reg;
  logic [15:0] word_next;
  logic [4:0]  bit_cnt;
  logic        word_ch;
  logic [15:0] left_hold;
  logic        left_pending;

  // Synchronise the three serial inputs; ws and d stay aligned with bclk.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      d_sync    <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_in};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      d_sync    <= {d_sync[SYNC_STAGES-2:0], d_in};
      bclk_prev <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign ws_s      = ws_sync[SYNC_STAGES-1];
  assign d_s       = d_sync[SYNC_STAGES-1];
  assign brise     = bclk_s & ~bclk_prev;
  assign ws_edge   = brise & (ws_s != ws_last);
  assign word_next = {shift_reg[14:0], d_s};

`ifdef I2S_IN_MONO_MIX_EN
  logic [15:0] mix_half;
  // Sign-extended 17-bit sum cannot overflow; the halved result fits 16 bits.
  assign mix_half = 16'((17'({left_hold[15], left_hold}) +
                         17'({word_next[15], word_next})) >> 1);
`endif

  // Framing FSM, deserialiser and registered frame outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state          <= IDLE;
      ws_last        <= 1'b0;
      shift_reg      <= '0;
      bit_cnt        <= '0;
      word_ch        <= 1'b0;
      left_hold      <= '0;
      left_pending   <= 1'b0;
      left_out       <= '0;
      right_out      <= '0;
      data_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
`ifdef I2S_IN_MONO_MIX_EN
      mono_out       <= '0;
`endif
    end else begin
      data_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
      if (brise) ws_last <= ws_s;

      if (ws_edge) begin
        // New word starts; the channel is fixed by the level seen here.
        word_ch <= ws_s;
        if (state == SHIFT && bit_cnt < 5'd16) begin
          frame_err_out <= 1'b1;
          left_pending  <= 1'b0;
        end
        if (MSB_DELAY == 0) begin
          shift_reg <= {15'd0, d_s};
          bit_cnt   <= 5'd1;
          state     <= SHIFT;
        end else begin
          bit_cnt   <= 5'd0;
          state     <= SKIP;
        end
      end else if (brise) begin
        case (state)
          SKIP: begin
            shift_reg <= {15'd0, d_s};
            bit_cnt   <= 5'd1;
            state     <= SHIFT;
          end
          SHIFT: begin
            shift_reg <= word_next;
            bit_cnt   <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state <= DONE;
              if (!word_ch) begin
                left_hold    <= word_next;
                left_pending <= 1'b1;
              end else if (left_pending) begin
                left_out       <= left_hold;
                right_out      <= word_next;
                data_valid_out <= 1'b1;
                left_pending   <= 1'b0;
`ifdef I2S_IN_MONO_MIX_EN
                mono_out       <= mix_half;
`endif
              end else begin
                // Right word with no preceding left word.
                frame_err_out <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_in.sv
// Directed bench for i2s_in: one standard-I2S instance and one
// left-justified instance, driven from a shared serial pin model.
module tb_i2s_in;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bclk = 1'b0;
  logic ws = 1'b0;
  logic d = 1'b0;
  logic sel = 1'b0;   // 0: drive standard instance, 1: left-justified instance

  logic bclk_a, bclk_b;
  assign bclk_a = sel ? 1'b0 : bclk;
  assign bclk_b = sel ? bclk : 1'b0;

  logic [15:0] left_a, right_a, left_b, right_b;
  logic        dv_a, fe_a, dv_b, fe_b;
`ifdef I2S_IN_MONO_MIX_EN
  logic [15:0] mono_a, mono_b;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int vld_a = 0, err_a = 0, vld_b = 0;

  always #5 clk = ~clk;

  i2s_in #(.MSB_DELAY(1), .SYNC_STAGES(2)) dut_a (
    .clk_in(clk), .reset_in(rst), .bclk_in(bclk_a), .ws_in(ws), .d_in(d),
    .left_out(left_a), .right_out(right_a),
    .data_valid_out(dv_a), .frame_err_out(fe_a)
`ifdef I2S_IN_MONO_MIX_EN
    , .mono_out(mono_a)
`endif
  );

  i2s_in #(.MSB_DELAY(0), .SYNC_STAGES(2)) dut_b (
    .clk_in(clk), .reset_in(rst), .bclk_in(bclk_b), .ws_in(ws), .d_in(d),
    .left_out(left_b), .right_out(right_b),
    .data_valid_out(dv_b), .frame_err_out(fe_b)
`ifdef I2S_IN_MONO_MIX_EN
    , .mono_out(mono_b)
`endif
  );

  // Count strobe cycles so that stuck or missing pulses show up.
  always @(posedge clk) begin
    if (dv_a) vld_a <= vld_a + 1;
    if (fe_a) err_a <= err_a + 1;
    if (dv_b) vld_b <= vld_b + 1;
  end

  // One half-frame: lead skip slots, nbits data bits MSB first, then pad.
  // bclk = clk/8 (4 clk low, 4 clk high); ws/d change while bclk is low.
  task automatic send_half(input logic w, input logic [15:0] word,
                           input int nbits, input int total, input logic pad);
    int k;
    int lead;
    lead = sel ? 0 : 1;
    for (int i = 0; i < total; i++) begin
      k = i - lead;
      ws = w;
      if (k < 0) d = 1'b0;
      else if (k < nbits) d = word[15-k];
      else d = pad;
      repeat (4) @(posedge clk);
      #1 bclk = 1'b1;
      repeat (4) @(posedge clk);
      #1 bclk = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bclk = 1'b0; ws = 1'b0; d = 1'b0; sel = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (left_a !== 16'h0000) begin $display("FAIL reset_left got %h want 0000", left_a); n_err++; end
    n_cmp++; if (right_a !== 16'h0000) begin $display("FAIL reset_right got %h want 0000", right_a); n_err++; end
    n_cmp++; if (dv_a !== 1'b0) begin $display("FAIL reset_valid got %b want 0", dv_a); n_err++; end
    n_cmp++; if (fe_a !== 1'b0) begin $display("FAIL reset_err got %b want 0", fe_a); n_err++; end
  endtask

  task automatic test_basic;
    int v0, e0;
    v0 = vld_a; e0 = err_a;
    send_half(1'b1, 16'h0000, 0, 1, 1'b0);   // one-slot preamble to create a left edge
    send_half(1'b0, 16'hA5C3, 16, 32, 1'b0);
    send_half(1'b1, 16'h1234, 16, 32, 1'b0);
    n_cmp++; if (vld_a - v0 !== 1) begin $display("FAIL basic_valid_count got %0d want 1", vld_a - v0); n_err++; end
    n_cmp++; if (err_a - e0 !== 0) begin $display("FAIL basic_err_count got %0d want 0", err_a - e0); n_err++; end
    n_cmp++; if (left_a !== 16'hA5C3) begin $display("FAIL basic_left got %h want a5c3", left_a); n_err++; end
    n_cmp++; if (right_a !== 16'h1234) begin $display("FAIL basic_right got %h want 1234", right_a); n_err++; end
  endtask

  task automatic test_trailing_bits;
    int v0, e0;
    v0 = vld_a; e0 = err_a;
    send_half(1'b0, 16'h8001, 16, 32, 1'b1);
    send_half(1'b1, 16'h7FFE, 16, 32, 1'b1);
    n_cmp++; if (vld_a - v0 !== 1) begin $display("FAIL trail_valid_count got %0d want 1", vld_a - v0); n_err++; end
    n_cmp++; if (err_a - e0 !== 0) begin $display("FAIL trail_err_count got %0d want 0", err_a - e0); n_err++; end
    n_cmp++; if (left_a !== 16'h8001) begin $display("FAIL trail_left got %h want 8001", left_a); n_err++; end
    n_cmp++; if (right_a !== 16'h7FFE) begin $display("FAIL trail_right got %h want 7ffe", right_a); n_err++; end
  endtask

  task automatic test_short_word;
    int v0, e0;
    v0 = vld_a; e0 = err_a;
    send_half(1'b0, 16'hABCD, 10, 11, 1'b0);  // ws toggles after 10 data bits
    n_cmp++; if (err_a - e0 !== 0) begin $display("FAIL short_err_early got %0d want 0", err_a - e0); n_err++; end
    send_half(1'b1, 16'h00FF, 16, 32, 1'b0);  // short left, then orphan right
    n_cmp++; if (err_a - e0 !== 2) begin $display("FAIL short_err_count got %0d want 2", err_a - e0); n_err++; end
    n_cmp++; if (vld_a - v0 !== 0) begin $display("FAIL short_valid_count got %0d want 0", vld_a - v0); n_err++; end
    n_cmp++; if (left_a !== 16'h8001) begin $display("FAIL short_left_held got %h want 8001", left_a); n_err++; end
    n_cmp++; if (right_a !== 16'h7FFE) begin $display("FAIL short_right_held got %h want 7ffe", right_a); n_err++; end
    v0 = vld_a; e0 = err_a;
    send_half(1'b0, 16'h0F0F, 16, 32, 1'b0);
    send_half(1'b1, 16'hF0F0, 16, 32, 1'b0);
    n_cmp++; if (vld_a - v0 !== 1) begin $display("FAIL recover_valid_count got %0d want 1", vld_a - v0); n_err++; end
    n_cmp++; if (err_a - e0 !== 0) begin $display("FAIL recover_err_count got %0d want 0", err_a - e0); n_err++; end
    n_cmp++; if (left_a !== 16'h0F0F) begin $display("FAIL recover_left got %h want 0f0f", left_a); n_err++; end
    n_cmp++; if (right_a !== 16'hF0F0) begin $display("FAIL recover_right got %h want f0f0", right_a); n_err++; end
  endtask

  task automatic test_reset_mid_word;
    int v0;
    send_half(1'b0, 16'h1111, 16, 32, 1'b0);
    send_half(1'b1, 16'h2222, 8, 9, 1'b0);    // half a right word, bclk low
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_cmp++; if (left_a !== 16'h0000) begin $display("FAIL midrst_left got %h want 0000", left_a); n_err++; end
    n_cmp++; if (right_a !== 16'h0000) begin $display("FAIL midrst_right got %h want 0000", right_a); n_err++; end
    n_cmp++; if (dv_a !== 1'b0 || fe_a !== 1'b0) begin $display("FAIL midrst_strobes got %b%b want 00", dv_a, fe_a); n_err++; end
    v0 = vld_a;
    send_half(1'b1, 16'h3333, 16, 32, 1'b0);  // right word with no left: no update
    n_cmp++; if (vld_a - v0 !== 0) begin $display("FAIL midrst_no_valid got %0d want 0", vld_a - v0); n_err++; end
    n_cmp++; if (right_a !== 16'h0000) begin $display("FAIL midrst_right_held got %h want 0000", right_a); n_err++; end
    send_half(1'b0, 16'h4444, 16, 32, 1'b0);
    send_half(1'b1, 16'h5555, 16, 32, 1'b0);
    n_cmp++; if (vld_a - v0 !== 1) begin $display("FAIL midrst_valid_count got %0d want 1", vld_a - v0); n_err++; end
    n_cmp++; if (left_a !== 16'h4444 || right_a !== 16'h5555) begin $display("FAIL midrst_frame got %h/%h want 4444/5555", left_a, right_a); n_err++; end
  endtask

`ifdef I2S_IN_MONO_MIX_EN
  task automatic test_mono;
    send_half(1'b0, 16'h7FFF, 16, 32, 1'b0);
    send_half(1'b1, 16'h7FFF, 16, 32, 1'b0);
    n_cmp++; if (mono_a !== 16'h7FFF) begin $display("FAIL mono_pos got %h want 7fff", mono_a); n_err++; end
    send_half(1'b0, 16'h8000, 16, 32, 1'b0);
    send_half(1'b1, 16'hFFFF, 16, 32, 1'b0);
    n_cmp++; if (mono_a !== 16'hBFFF) begin $display("FAIL mono_neg got %h want bfff", mono_a); n_err++; end
  endtask
`endif

  task automatic test_left_justified;
    int v0;
    sel = 1'b1;
    v0 = vld_b;
    send_half(1'b1, 16'h0000, 0, 1, 1'b0);
    send_half(1'b0, 16'h8000, 16, 32, 1'b0);
    send_half(1'b1, 16'h0001, 16, 32, 1'b0);
    n_cmp++; if (vld_b - v0 !== 1) begin $display("FAIL lj_valid_count got %0d want 1", vld_b - v0); n_err++; end
    n_cmp++; if (left_b !== 16'h8000) begin $display("FAIL lj_left got %h want 8000", left_b); n_err++; end
    n_cmp++; if (right_b !== 16'h0001) begin $display("FAIL lj_right got %h want 0001", right_b); n_err++; end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trailing_bits();
    test_short_word();
    test_reset_mid_word();
`ifdef I2S_IN_MONO_MIX_EN
    test_mono();
`endif
    test_left_justified();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
